// File: rtl/trigger_capture.sv
// trigger_capture: pre/post-trigger sample capture buffer.
//
// Samples from the trigger stage are written into a circular RAM while an
// acquisition is running. The first trigger after arming (once PRE_TRIG samples
// have been collected) freezes a DEPTH-sample window: PRE_TRIG samples before
// the trigger, the trigger sample itself, and the samples after it. The frozen
// window is then read out oldest-first, one sample per I_RD_EN cycle.
//
// Optional feature: define TRIG_CAP_TIMESTAMP_EN to timestamp the trigger sample
// (count of accepted samples since arm). When it is undefined, O_TRIG_TS is 0.
//
// Ports:
//   I_CLK      clock, rising edge
//   I_RST      asynchronous active-high reset
//   I_DIN      sample data from the trigger stage
//   I_DEN      sample valid
//   I_TRIG_ON  trigger flag, aligned with I_DIN/I_DEN
//   I_ARM      start an acquisition (pulse)
//   I_ABORT    cancel acquisition or readout
//   I_RD_EN    read request, one sample per cycle
//   O_RD_DATA  read sample (holds between reads)
//   O_RD_DV    O_RD_DATA valid pulse, one cycle after I_RD_EN
//   O_RD_LAST  marks the final (DEPTH-th) read sample
//   O_BUSY     acquisition in progress
//   O_DONE     window frozen, readout available
//   O_TRIG_TS  trigger timestamp
module trigger_capture #(
    parameter int unsigned DWL      = 8,
    parameter int unsigned AWL      = 10,
    parameter int unsigned PRE_TRIG = 256,
    parameter int unsigned TSW      = 32
) (
    input  logic           I_CLK,
    input  logic           I_RST,
    input  logic [DWL-1:0] I_DIN,
    input  logic           I_DEN,
    input  logic           I_TRIG_ON,
    input  logic           I_ARM,
    input  logic           I_ABORT,
    input  logic           I_RD_EN,
    output logic [DWL-1:0] O_RD_DATA,
    output logic           O_RD_DV,
    output logic           O_RD_LAST,
    output logic           O_BUSY,
    output logic           O_DONE,
    output logic [TSW-1:0] O_TRIG_TS
);

    localparam int unsigned DEPTH  = 2 ** AWL;
    localparam int unsigned POST_N = DEPTH - PRE_TRIG;

    // Counters are one bit wider than the address so they can hold DEPTH.
    localparam logic [AWL:0]   PRE_LAST  = (AWL + 1)'(PRE_TRIG - 1);
    localparam logic [AWL:0]   POST_LAST = (AWL + 1)'(POST_N - 1);
    localparam logic [AWL:0]   RD_TOTAL  = (AWL + 1)'(DEPTH);
    localparam logic [AWL:0]   RD_FINAL  = (AWL + 1)'(DEPTH - 1);
    localparam logic [AWL:0]   CNT_ONE   = (AWL + 1)'(1);
    localparam logic [AWL-1:0] PRE_OFS   = AWL'(PRE_TRIG);

    typedef enum logic [2:0] {StIdle, StPre, StWait, StPost, StDone} state_t;

    state_t         state;
    logic [AWL-1:0] wr_ptr;
    logic [AWL-1:0] rd_ptr;
    logic [AWL-1:0] trig_addr;
    logic [AWL:0]   pre_cnt;
    logic [AWL:0]   post_cnt;
    logic [AWL:0]   rd_cnt;
    logic [DWL-1:0] mem [DEPTH];

    logic accept;
    logic arm_fire;
    logic trig_hit;
    logic rd_fire;

    assign accept   = I_DEN && (state == StPre || state == StWait || state == StPost);
    assign arm_fire = I_ARM && !I_ABORT && (state == StIdle || state == StDone);
    assign trig_hit = accept && !I_ABORT && (state == StWait) && I_TRIG_ON;
    // Arm takes priority over a read in the same DONE cycle.
    assign rd_fire  = I_RD_EN && !I_ABORT && !I_ARM && (state == StDone) && (rd_cnt < RD_TOTAL);

    // Write port; the RAM is frozen outside the acquiring states.
    always_ff @(posedge I_CLK) begin
        if (accept) begin
            mem[wr_ptr] <= I_DIN;
        end
    end

    // Synchronous read port.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            O_RD_DATA <= '0;
        end else if (rd_fire) begin
            O_RD_DATA <= mem[rd_ptr];
        end
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state     <= StIdle;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            trig_addr <= '0;
            pre_cnt   <= '0;
            post_cnt  <= '0;
            rd_cnt    <= '0;
            O_RD_DV   <= 1'b0;
            O_RD_LAST <= 1'b0;
            O_BUSY    <= 1'b0;
            O_DONE    <= 1'b0;
        end else begin
            O_RD_DV   <= 1'b0;
            O_RD_LAST <= 1'b0;
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (I_ABORT) begin
                state  <= StIdle;
                O_BUSY <= 1'b0;
                O_DONE <= 1'b0;
            end else begin
                unique case (state)
                    StIdle, StDone: begin
                        if (arm_fire) begin
                            wr_ptr  <= '0;
                            pre_cnt <= '0;
                            O_BUSY  <= 1'b1;
                            O_DONE  <= 1'b0;
                            state   <= (PRE_TRIG == 0) ? StWait : StPre;
                        end else if (rd_fire) begin
                            O_RD_DV   <= 1'b1;
                            O_RD_LAST <= (rd_cnt == RD_FINAL);
                            rd_ptr    <= rd_ptr + 1'b1;
                            rd_cnt    <= rd_cnt + 1'b1;
                        end
                    end
                    StPre: begin
                        // Triggers are ignored here, including on the final PRE write.
                        if (accept) begin
                            pre_cnt <= pre_cnt + 1'b1;
                            if (pre_cnt == PRE_LAST) begin
                                state <= StWait;
                            end
                        end
                    end
                    StWait: begin
                        if (trig_hit) begin
                            trig_addr <= wr_ptr;
                            post_cnt  <= CNT_ONE;
                            if (POST_N == 1) begin
                                // Trigger sample alone completes the window.
                                state  <= StDone;
                                O_BUSY <= 1'b0;
                                O_DONE <= 1'b1;
                                rd_ptr <= wr_ptr - PRE_OFS;
                                rd_cnt <= '0;
                            end else begin
                                state <= StPost;
                            end
                        end
                    end
                    StPost: begin
                        if (accept) begin
                            post_cnt <= post_cnt + 1'b1;
                            if (post_cnt == POST_LAST) begin
                                state  <= StDone;
                                O_BUSY <= 1'b0;
                                O_DONE <= 1'b1;
                                // Oldest sample of the window sits PRE_TRIG before the trigger.
                                rd_ptr <= trig_addr - PRE_OFS;
                                rd_cnt <= '0;
                            end
                        end
                    end
                    default: begin
                        state  <= StIdle;
                        O_BUSY <= 1'b0;
                        O_DONE <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef TRIG_CAP_TIMESTAMP_EN
    logic [TSW-1:0] ts_cnt;

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            ts_cnt    <= '0;
            O_TRIG_TS <= '0;
        end else if (arm_fire) begin
            ts_cnt    <= '0;
            O_TRIG_TS <= '0;
        end else begin
            if (accept) begin
                ts_cnt <= ts_cnt + 1'b1;
            end
            // Count before increment, so the first sample after arm stamps as 0.
            if (trig_hit) begin
                O_TRIG_TS <= ts_cnt;
            end
        end
    end
`else
    assign O_TRIG_TS = '0;
`endif

endmodule

// File: tb/tb_trigger_capture.sv
// Bench for trigger_capture with DEPTH=16, PRE_TRIG=4. A sample-list model
// predicts every output each cycle; literal expectations pin the readout windows.
module tb_trigger_capture;

    localparam int DWL    = 8;
    localparam int AWL    = 4;
    localparam int DEPTH  = 16;
    localparam int PRE    = 4;
    localparam int POST_N = DEPTH - PRE;
    localparam int TSW    = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [DWL-1:0] din;
    logic           den, trig_on, arm, abort_s, rd_en;
    logic [DWL-1:0] rd_data;
    logic           rd_dv, rd_last, busy, done;
    logic [TSW-1:0] trig_ts;

    trigger_capture #(
        .DWL(DWL), .AWL(AWL), .PRE_TRIG(PRE), .TSW(TSW)
    ) dut (
        .I_CLK(clk), .I_RST(rst), .I_DIN(din), .I_DEN(den), .I_TRIG_ON(trig_on),
        .I_ARM(arm), .I_ABORT(abort_s), .I_RD_EN(rd_en),
        .O_RD_DATA(rd_data), .O_RD_DV(rd_dv), .O_RD_LAST(rd_last),
        .O_BUSY(busy), .O_DONE(done), .O_TRIG_TS(trig_ts)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: list of samples accepted since arm, trigger index in that list.
    bit             m_collect, m_done, m_dv, m_last;
    int             samples[$];
    int             trig_idx, reads;
    logic [DWL-1:0] m_data;
    logic [TSW-1:0] m_ts;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_collect = 0; m_done = 0; m_dv = 0; m_last = 0;
            samples.delete(); trig_idx = -1; reads = 0; m_data = '0; m_ts = '0;
        end else begin
            m_dv = 0;
            m_last = 0;
            if (abort_s) begin
                m_collect = 0;
                m_done = 0;
            end else if (arm && !m_collect) begin
                samples.delete(); trig_idx = -1; reads = 0; m_ts = '0;
                m_collect = 1; m_done = 0;
            end else if (m_collect && den) begin
                samples.push_back(int'(din));
                if (trig_idx < 0 && samples.size() - 1 >= PRE && trig_on) begin
                    trig_idx = samples.size() - 1;
                    m_ts = TSW'(trig_idx);
                end
                if (trig_idx >= 0 && samples.size() == trig_idx + POST_N) begin
                    m_collect = 0;
                    m_done = 1;
                    reads = 0;
                end
            end else if (m_done && rd_en && reads < DEPTH) begin
                m_data = DWL'(samples[trig_idx - PRE + reads]);
                m_dv = 1;
                m_last = (reads == DEPTH - 1);
                reads++;
            end
        end
    end

    int rd_log[$];
    int last_seen;

    always @(posedge clk) begin
        logic [TSW-1:0] exp_ts;
        #1;
`ifdef TRIG_CAP_TIMESTAMP_EN
        exp_ts = m_ts;
`else
        exp_ts = '0;
`endif
        check("busy", busy, m_collect);
        check("done", done, m_done);
        check("rd_dv", rd_dv, m_dv);
        check("rd_last", rd_last, m_last);
        check("rd_data", rd_data, m_data);
        check("trig_ts", trig_ts, exp_ts);
        if (rd_dv) rd_log.push_back(int'(rd_data));
        if (rd_dv && rd_last) last_seen = int'(rd_data);
    end

    task automatic do_arm();
        @(negedge clk) arm = 1'b1;
        @(negedge clk) arm = 1'b0;
    endtask

    // mode 0: den always; 1: trigger flag held high; 2: den every other cycle.
    // stop_v >= 0 stops once that many samples were driven.
    task automatic acquire(input int trig_val, input int mode, input int stop_v);
        int v = 0;
        int cyc = 0;
        bit ph = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (stop_v >= 0 && v == stop_v) break;
            if (cyc > 600) begin
                vectors++;
                miscompares++;
                $display("FAIL acquire_timeout: got no DONE after %0d cycles, expected DONE", cyc);
                break;
            end
            den = (mode == 2) ? ph : 1'b1;
            ph = !ph;
            din = v[DWL-1:0];
            trig_on = (mode == 1) ? 1'b1 : (den && v == trig_val);
            if (den) v++;
            cyc++;
        end
        den = 1'b0;
        trig_on = 1'b0;
    endtask

    task automatic read_n(input int n);
        rd_log.delete();
        last_seen = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk) rd_en = 1'b1;
        end
        @(negedge clk) rd_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_window(input string name, input int start);
        check({name, "_count"}, rd_log.size(), DEPTH);
        for (int i = 0; i < rd_log.size() && i < DEPTH; i++) begin
            check(name, rd_log[i], start + i);
        end
        check({name, "_last"}, last_seen, start + DEPTH - 1);
    endtask

    initial begin
        rst = 1'b1; din = '0; den = 0; trig_on = 0; arm = 0; abort_s = 0; rd_en = 0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_dv", rd_dv, 0);
        check("reset_data", rd_data, 0);
        check("reset_ts", trig_ts, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Trigger at 20, continuous valid.
        do_arm();
        check("armed_busy", busy, 1);
        acquire(20, 0, -1);
`ifdef TRIG_CAP_TIMESTAMP_EN
        check("ts_trig20", trig_ts, 20);
`else
        check("ts_tied0", trig_ts, 0);
`endif
        read_n(DEPTH);
        check_window("win_trig20", 16);
        read_n(2);
        check("read_past_end", rd_log.size(), 0);

        // Re-arm from DONE; trigger flag held high.
        do_arm();
        check("rearm_busy", busy, 1);
        check("rearm_ts", trig_ts, 0);
        acquire(0, 1, -1);
        read_n(DEPTH);
        check_window("win_trig_const", 0);

        // Valid toggling every other cycle.
        do_arm();
        acquire(20, 2, -1);
        read_n(DEPTH);
        check_window("win_toggle", 16);

        // Buffer wrapped several times.
        do_arm();
        acquire(100, 0, -1);
        read_n(DEPTH);
        check_window("win_trig100", 96);

        // Abort in POST, then a fresh acquisition.
        do_arm();
        acquire(20, 0, 26);
        @(negedge clk) abort_s = 1'b1;
        @(negedge clk) abort_s = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        read_n(3);
        check("abort_no_read", rd_log.size(), 0);
        do_arm();
        acquire(20, 0, -1);
        read_n(DEPTH);
        check_window("win_after_abort", 16);

        // Reset in the middle of readout.
        do_arm();
        acquire(20, 0, -1);
        rd_log.delete();
        @(negedge clk) rd_en = 1'b1;
        repeat (5) @(negedge clk);
        check("pre_reset_dv", rd_dv, 1);
        #1 rst = 1'b1;
        #1;
        check("midrd_reset_dv", rd_dv, 0);
        check("midrd_reset_last", rd_last, 0);
        check("midrd_reset_data", rd_data, 0);
        check("midrd_reset_done", done, 0);
        check("midrd_reset_busy", busy, 0);
        check("midrd_reset_ts", trig_ts, 0);
        @(negedge clk) rd_en = 1'b0;
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
